// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 inverse key-schedule slice.
//   NR_AES128 : number of rounds for AES-128
//   RCON      : round constants, indexed by round 1..10
//   state_t   : sequencer states for the key generator
//   byte_at   : bit offset of byte (row r, column c) in the 128-bit state layout
//   rcon_of   : safe Rcon lookup, returns 0 outside rounds 1..10
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // Row r occupies bits [32r+31:32r]; column c is byte c within the row.
    function automatic int unsigned byte_at(input int unsigned r, input int unsigned c);
        return 32 * r + 8 * c;
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] round);
        if (round >= 4'd1 && round <= 4'd10) begin
            return RCON[int'(round)];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_sbox_fwd.sv
// Forward AES S-box, purely combinational table lookup.
//   value : input byte
//   subst : substituted byte
module aes_sbox_fwd (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign subst = SBOX[value];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key-schedule generator.
// Loads the round-NR key, then streams round keys NR..0 over a valid/ready
// handshake, deriving each previous key on the fly from the current one.
//   clk       : system clock
//   rst       : synchronous active-high reset (aborts a running sequence)
//   start     : load last_key and begin; only sampled while idle
//   last_key  : round-NR key in state layout
//   key_out   : current round key in state layout
//   key_round : round index of key_out
//   key_valid : key_out/key_round valid
//   key_ready : consumer accepts the key this cycle
//   busy      : a sequence is in progress
//   done      : one-cycle pulse after the round-0 key is accepted
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    if (NR != int'(NR_AES128)) begin : g_nr_check
        $error("aes_inv_key_sched supports only NR = 10 (AES-128)");
    end

    state_t       state_q, state_d;
    logic [127:0] key_reg, key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;

    // Byte view of the current key plus the SubWord/RotWord operands.
    logic [7:0]   cur     [4][4];
    logic [7:0]   w3p     [4];
    logic [7:0]   sub_in  [4];
    logic [7:0]   sub_out [4];
    logic [127:0] key_prev;

    always_comb begin
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                cur[r][c] = key_reg[byte_at(r, c) +: 8];
            end
        end
        for (int unsigned r = 0; r < 4; r++) begin
            w3p[r] = cur[r][3] ^ cur[r][2];
        end
        // RotWord: row r of the rotated word comes from row r+1.
        for (int unsigned r = 0; r < 4; r++) begin
            sub_in[r] = w3p[(r + 1) % 4];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox_fwd u_sbox (
            .value (sub_in[g]),
            .subst (sub_out[g])
        );
    end

    always_comb begin
        key_prev = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            key_prev[byte_at(r, 3) +: 8] = w3p[r];
            key_prev[byte_at(r, 2) +: 8] = cur[r][2] ^ cur[r][1];
            key_prev[byte_at(r, 1) +: 8] = cur[r][1] ^ cur[r][0];
            key_prev[byte_at(r, 0) +: 8] = cur[r][0] ^ sub_out[r]
                                         ^ ((r == 0) ? rcon_of(round_q) : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_reg <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_reg <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_reg;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = last_key;
                    round_d = 4'(NR);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (round_q != 4'd0) begin
                        key_d   = key_prev;
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_out   = key_reg;
    assign key_round = round_q;
    assign key_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched. Expected keys come from a
// forward FIPS-197 key expansion (or a word-wise inverse walk) computed here
// from GF(2^8) arithmetic, repacked into the state layout.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst, start, key_ready;
    logic [127:0] last_key;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid, busy, done;

    always #5 clk = ~clk;

    aes_inv_key_sched #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last_key  (last_key),
        .key_out   (key_out),
        .key_round (key_round),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb [256];
    logic [7:0]   rc [1:10];
    logic [127:0] exp_keys [0:10];
    logic [127:0] last_r9;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rc[i] = gmul(rc[i-1], 8'h02);
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // FIPS word w[c] (first byte = row 0 in the MSBs) -> state layout.
    function automatic logic [127:0] to_state(input logic [3:0][31:0] ws);
        logic [127:0] s = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[32*r + 8*c +: 8] = ws[c][31 - 8*r -: 8];
        return s;
    endfunction

    function automatic logic [3:0][31:0] from_state(input logic [127:0] s);
        logic [3:0][31:0] ws;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                ws[c][31 - 8*r -: 8] = s[32*r + 8*c +: 8];
        return ws;
    endfunction

    // 128-bit FIPS byte string (k0 in MSBs) -> state layout.
    function automatic logic [127:0] fips_pack(input logic [127:0] x);
        return to_state({x[31:0], x[63:32], x[95:64], x[127:96]});
    endfunction

    task automatic fill_forward(input logic [127:0] cipher);
        logic [31:0] w [44];
        for (int i = 0; i < 4; i++) w[i] = cipher[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) t = sub_word(rot_word(t)) ^ {rc[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_keys[r] = to_state({w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]});
    endtask

    task automatic fill_inverse(input logic [127:0] last_state);
        logic [31:0] w [44];
        logic [3:0][31:0] ws = from_state(last_state);
        for (int c = 0; c < 4; c++) w[40+c] = ws[c];
        for (int i = 43; i >= 4; i--) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) t = sub_word(rot_word(t)) ^ {rc[i/4], 24'h0};
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_keys[r] = to_state({w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]});
    endtask

    // ---------------- sequence driver/checker ----------------
    task automatic run_seq(input logic [127:0] lk, input bit rand_ready, input int abort_at,
                           input bit inject, input bit skip_start, input bit chain_zero);
        int           exp_round = 10;
        int           accepts = 0;
        int           budget = 0;
        bit           finished = 1'b0;
        bit           stalled = 1'b0;
        logic [127:0] prev_key;
        logic [3:0]   prev_round;
        if (!skip_start) begin
            last_key = lk;
            start    = 1'b1;
            step();
            start    = 1'b0;
            last_key = {$urandom, $urandom, $urandom, $urandom};
        end
        check("latency", {key_valid, busy, key_round}, {1'b1, 1'b1, 4'd10});
        while (!finished) begin
            if (budget++ > 300) begin
                check("timeout", 128'd0, 128'd1);
                return;
            end
            check("valid", key_valid, 1);
            check("round", key_round, exp_round);
            check("key", key_out, exp_keys[exp_round]);
            check("done_low", done, 0);
            if (stalled) check("stall_hold", {key_round, key_out}, {prev_round, prev_key});
            if (exp_round == 9) last_r9 = key_out;
            if (exp_round == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("abort_out", {key_valid, busy, done, key_out}, 0);
                repeat (15) begin
                    step();
                    check("abort_no_done", {done, key_valid}, 0);
                end
                return;
            end
            key_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            if (inject && ($urandom % 3 == 0)) begin
                start    = 1'b1;
                last_key = {$urandom, $urandom, $urandom, $urandom};
            end
            prev_key   = key_out;
            prev_round = key_round;
            stalled    = !key_ready;
            if (key_ready) accepts++;
            step();
            start = 1'b0;
            if (!stalled) begin
                if (exp_round == 0) begin
                    finished = 1'b1;
                    check("done_pulse", {done, key_valid, busy}, {1'b1, 1'b0, 1'b0});
                    check("accepts", accepts, 11);
                end else begin
                    exp_round--;
                end
            end
        end
        if (chain_zero) begin
            last_key = '0;
            start    = 1'b1;
            step();
            start    = 1'b0;
        end else begin
            step();
            check("done_once", {done, key_valid}, 0);
        end
    endtask

    localparam logic [127:0] FIPS_CIPHER = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        key_ready = 1'b0;
        last_key  = '0;
        build_tables();
        step();
        step();
        check("reset_state", {key_out, key_round, key_valid, busy, done}, 0);
        rst       = 1'b0;
        key_ready = 1'b1;
        repeat (20) begin
            step();
            check("idle_outputs", {key_out, key_round, key_valid, busy, done}, 0);
        end

        // FIPS-197 vector: literal keys for rounds 10, 9, 1, 0, model for the rest.
        fill_forward(FIPS_CIPHER);
        exp_keys[10] = fips_pack(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        exp_keys[9]  = fips_pack(128'hac7766f319fadc2128d12941575c006e);
        exp_keys[1]  = fips_pack(128'ha0fafe1788542cb123a339392a6c7605);
        exp_keys[0]  = fips_pack(FIPS_CIPHER);
        run_seq(exp_keys[10], 1'b0, -1, 1'b0, 1'b0, 1'b0);
        run_seq(exp_keys[10], 1'b1, -1, 1'b0, 1'b0, 1'b0);
        run_seq(exp_keys[10], 1'b1, 5, 1'b0, 1'b0, 1'b0);
        run_seq(exp_keys[10], 1'b0, -1, 1'b0, 1'b0, 1'b0);

        // Restart attempts during EMIT, then restart with all-zero key in the done cycle.
        run_seq(exp_keys[10], 1'b1, -1, 1'b1, 1'b0, 1'b1);
        fill_inverse('0);
        run_seq('0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        check("rcon36_byte", last_r9[7:0], 8'h55);

        // Random cipher keys with random back-pressure and ignored restarts.
        repeat (4) begin
            fill_forward({$urandom, $urandom, $urandom, $urandom});
            run_seq(exp_keys[10], 1'b1, -1, 1'b1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
